cpu_trace_emitter: RTL and testbench

Serialises one CPU write-back record per handshake into the ASCII trace line format consumed by the trace-format checker. Emits one character per clock, with no gaps inside a line. Register writes produce `^T@PPPPPPPP: $G <= DDDDDDDD#`; memory writes produce `^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#`. It sits directly upstream of the checker: its `char` output drives the checker's `char` input.

---
 rtl/cpu_trace_emitter.sv | 151 +++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_emitter.sv
// Serialises one CPU write-back record into an ASCII trace line, one char per clock.
// Latency: '^' appears the cycle after the capture edge; then one char per cycle, no gaps.
// Backpressure: in_ready only in IDLE and on the '#' cycle; offered records wait.
module cpu_trace_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_grf,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        line_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_SIGIL,
    S_ARG, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
  } state_t;

  state_t           state, nxt_state;
  logic [2:0]       idx, nxt_idx;
  logic [7:0]       nxt_char;
  logic             accept;

  logic             kind_q;
  logic [31:0]      pc_q, addr_q, data_q;
  logic [3:0][3:0]  t_dig;
  logic [2:0]       t_len;
  logic [1:0][3:0]  g_dig;
  logic [2:0]       g_len;

  logic [13:0]      t_sat;
  logic [3:0][3:0]  t_dig_cap;
  logic [2:0]       t_len_cap;
  logic [2:0]       t_pos, g_pos;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Nibble 0 is the most significant one.
  function automatic logic [3:0] nib(input logic [31:0] v, input logic [2:0] i);
    return v[{~i, 2'b00} +: 4];
  endfunction

  assign in_ready = (state == S_IDLE) || (state == S_HASH);
  assign accept   = in_valid && in_ready;

  always_comb begin
    t_sat        = (in_time > 14'd9999) ? 14'd9999 : in_time;
    t_dig_cap[3] = 4'(t_sat / 14'd1000);
    t_dig_cap[2] = 4'((t_sat / 14'd100) % 14'd10);
    t_dig_cap[1] = 4'((t_sat / 14'd10) % 14'd10);
    t_dig_cap[0] = 4'(t_sat % 14'd10);
    if (t_sat >= 14'd1000)     t_len_cap = 3'd4;
    else if (t_sat >= 14'd100) t_len_cap = 3'd3;
    else if (t_sat >= 14'd10)  t_len_cap = 3'd2;
    else                       t_len_cap = 3'd1;
  end

  always_comb begin
    nxt_state = state;
    nxt_idx   = 3'd0;
    case (state)
      S_IDLE:  if (accept) nxt_state = S_CARET;
      S_CARET: nxt_state = S_TIME;
      S_TIME:  if (idx == t_len - 3'd1) nxt_state = S_AT;
               else nxt_idx = idx + 3'd1;
      S_AT:    nxt_state = S_PC;
      S_PC:    if (idx == 3'd7) nxt_state = S_COLON;
               else nxt_idx = idx + 3'd1;
      S_COLON: nxt_state = S_SP1;
      S_SP1:   nxt_state = S_SIGIL;
      S_SIGIL: nxt_state = S_ARG;
      S_ARG:   if ((kind_q && idx == 3'd7) || (!kind_q && idx == g_len - 3'd1)) nxt_state = S_SP2;
               else nxt_idx = idx + 3'd1;
      S_SP2:   nxt_state = S_LT;
      S_LT:    nxt_state = S_EQ;
      S_EQ:    nxt_state = S_SP3;
      S_SP3:   nxt_state = S_DATA;
      S_DATA:  if (idx == 3'd7) nxt_state = S_HASH;
               else nxt_idx = idx + 3'd1;
      S_HASH:  nxt_state = accept ? S_CARET : S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Output char is looked up for the state being entered, so char is a pure register.
  always_comb begin
    t_pos    = t_len - 3'd1 - nxt_idx;
    g_pos    = g_len - 3'd1 - nxt_idx;
    nxt_char = 8'h00;
    case (nxt_state)
      S_CARET: nxt_char = 8'h5e;
      S_TIME:  nxt_char = 8'h30 + {4'h0, t_dig[t_pos[1:0]]};
      S_AT:    nxt_char = 8'h40;
      S_PC:    nxt_char = hex_char(nib(pc_q, nxt_idx));
      S_COLON: nxt_char = 8'h3a;
      S_SP1, S_SP2, S_SP3: nxt_char = 8'h20;
      S_SIGIL: nxt_char = kind_q ? 8'h2a : 8'h24;
      S_ARG:   nxt_char = kind_q ? hex_char(nib(addr_q, nxt_idx))
                                 : (8'h30 + {4'h0, g_dig[g_pos[0]]});
      S_LT:    nxt_char = 8'h3c;
      S_EQ:    nxt_char = 8'h3d;
      S_DATA:  nxt_char = hex_char(nib(data_q, nxt_idx));
      S_HASH:  nxt_char = 8'h23;
      default: nxt_char = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      char       <= 8'h00;
      char_valid <= 1'b0;
      line_done  <= 1'b0;
      kind_q     <= 1'b0;
      pc_q       <= 32'h0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      t_dig      <= '0;
      t_len      <= 3'd0;
      g_dig      <= '0;
      g_len      <= 3'd0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      char       <= nxt_char;
      char_valid <= (nxt_state != S_IDLE);
      line_done  <= (nxt_state == S_HASH);
      if (accept) begin
        kind_q   <= in_kind;
        pc_q     <= in_pc;
        addr_q   <= in_addr;
        data_q   <= in_data;
        t_dig    <= t_dig_cap;
        t_len    <= t_len_cap;
        g_dig[1] <= 4'(in_grf / 5'd10);
        g_dig[0] <= 4'(in_grf % 5'd10);
        g_len    <= (in_grf >= 5'd10) ? 3'd2 : 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Self-checking bench for cpu_trace_emitter: table of records, scoreboard of expected chars.
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_grf;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  char;
  logic        char_valid;
  logic        line_done;

  cpu_trace_emitter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_time(in_time), .in_pc(in_pc), .in_grf(in_grf),
    .in_addr(in_addr), .in_data(in_data), .char(char), .char_valid(char_valid),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [13:0] tm;
    logic [31:0] pc;
    logic [4:0]  grf;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
  } rec_t;

  rec_t vec [8];
  byte  exp_q [$];
  int   len_q [$];
  int   cur_len;
  int   exp_len;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input rec_t r);
    in_kind = r.kind; in_time = r.tm; in_pc = r.pc; in_grf = r.grf;
    in_addr = r.addr; in_data = r.data; exp_len = r.len;
  endtask

  task automatic scramble();
    in_kind = 1'($urandom); in_time = 14'($urandom); in_pc = $urandom;
    in_grf = 5'($urandom); in_addr = $urandom; in_data = $urandom;
  endtask

  // Offer a record and return #1 after the edge that takes it.
  task automatic send(input rec_t r, input bit hold);
    int n;
    bit got;
    n = 0; got = 1'b0;
    drive(r);
    in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!got) chk("send_timeout", 32'(got), 32'd1);
    if (!hold) begin
      in_valid = 1'b0;
      scramble();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk); n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    string s;
    byte   e;
    vec[0] = '{1'b0, 14'd12,    32'h00003000, 5'd5,  32'h0,        32'h0000abcd, 29};
    vec[1] = '{1'b1, 14'd0,     32'h00003004, 5'd0,  32'h00000010, 32'hffffffff, 35};
    vec[2] = '{1'b0, 14'h3fff,  32'hdeadbeef, 5'd31, 32'h0,        32'h12345678, 32};
    vec[3] = '{1'b1, 14'd999,   32'h0,        5'd0,  32'hcafef00d, 32'h0,        37};
    vec[4] = '{1'b0, 14'd1000,  32'h89abcdef, 5'd0,  32'h0,        32'h00000001, 31};
    vec[5] = '{1'b0, 14'd9,     32'h00400000, 5'd10, 32'h0,        32'h7fffffff, 29};
    vec[6] = '{1'b1, 14'd9999,  32'h0040001c, 5'd3,  32'h10010000, 32'h80000000, 38};
    vec[7] = '{1'b0, 14'd100,   32'h00000004, 5'd9,  32'h0,        32'h0badf00d, 30};

    checks = 0; errors = 0; cur_len = 0; exp_len = 0;
    reset = 1'b1; in_valid = 1'b0;
    in_kind = 1'b0; in_time = '0; in_pc = '0; in_grf = '0; in_addr = '0; in_data = '0;

    fork
      forever begin
        @(clk);
        if (clk) begin
          if (reset) begin
            exp_q.delete(); len_q.delete(); cur_len = 0;
          end else if (in_valid && in_ready) begin
            if (in_kind)
              s = $sformatf("^%0d@%08h: *%08h <= %08h#",
                            (in_time > 14'd9999) ? 14'd9999 : in_time, in_pc, in_addr, in_data);
            else
              s = $sformatf("^%0d@%08h: $%0d <= %08h#",
                            (in_time > 14'd9999) ? 14'd9999 : in_time, in_pc, in_grf, in_data);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            len_q.push_back(exp_len);
          end
        end else if (!reset) begin
          if (char_valid) begin
            if (exp_q.size() == 0) begin
              chk("spurious_char", 32'(char_valid), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("char", 32'(char), 32'(e));
              chk("line_done", 32'(line_done), 32'(e == 8'h23));
              cur_len++;
              if (e == 8'h23) begin
                chk("line_len", 32'(cur_len), 32'(len_q.pop_front()));
                cur_len = 0;
              end
            end
          end else begin
            chk("idle_char", 32'(char), 32'd0);
            chk("idle_line_done", 32'(line_done), 32'd0);
            if (exp_q.size() > 0) chk("gap", 32'(char_valid), 32'd1);
          end
          chk("in_ready", 32'(in_ready), 32'(!char_valid || char == 8'h23));
        end
      end

      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_char", 32'(char), 32'd0);
        chk("rst_char_valid", 32'(char_valid), 32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Individual lines with idle gaps; fields scrambled mid-line.
        for (int i = 0; i < 8; i++) begin
          send(vec[i], 1'b0);
          if (i % 2 == 1) drain();
        end
        drain();

        // Back-to-back with in_valid held high.
        send(vec[0], 1'b1);
        send(vec[1], 1'b1);
        send(vec[2], 1'b0);
        drain();

        // Record offered during reset must be dropped.
        @(posedge clk); #1;
        reset = 1'b1;
        drive(vec[3]);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("drop_in_reset", 32'(char_valid), 32'd0);
        repeat (3) @(negedge clk);

        // Reset during the PC field abandons the line.
        @(posedge clk); #1;
        send(vec[0], 1'b0);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_char", 32'(char), 32'd0);
        chk("midrst_char_valid", 32'(char_valid), 32'd0);
        chk("midrst_line_done", 32'(line_done), 32'd0);
        @(posedge clk); #1;
        send(vec[2], 1'b0);
        drain();
      end
    join_any
    disable fork;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
